// File: rtl/cdc_pkg.sv
// cdc_pkg: shared FSM encoding and ID-width helper for the bus arbiter.
package cdc_pkg;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational rotate-priority picker, first request at or after ptr_i wins.
module rr_picker #(
    parameter int NB_REQ = 4,
    parameter int ID_W   = 2
) (
    input  logic [NB_REQ-1:0] req_i,
    input  logic [ID_W-1:0]   ptr_i,
    output logic [NB_REQ-1:0] grant_o,
    output logic [ID_W-1:0]   idx_o,
    output logic              any_o
);

    logic [ID_W-1:0] cand;

    // Scan from the farthest offset down so the nearest request to ptr_i wins.
    always_comb begin
        idx_o = '0;
        cand  = '0;
        for (int i = NB_REQ - 1; i >= 0; i--) begin
            cand = ID_W'((int'(ptr_i) + i) % NB_REQ);
            if (req_i[cand]) idx_o = cand;
        end
    end

    assign any_o   = |req_i;
    assign grant_o = any_o ? (NB_REQ'(1) << idx_o) : '0;

endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin N:1 stream arbiter with a single registered output slot.
module data_bus_arbiter
    import cdc_pkg::*;
#(
    parameter  int NB_REQ    = 4,
    parameter  int BUS_WIDTH = 8,
    localparam int ID_W      = id_width(NB_REQ)
) (
    input  logic                        aclk,
    input  logic                        arst,
    input  logic [NB_REQ-1:0]           tvalid_i,
    output logic [NB_REQ-1:0]           tready_i,
    input  logic [NB_REQ*BUS_WIDTH-1:0] tdata_i,
    output logic                        tvalid_o,
    input  logic                        tready_o,
    output logic [BUS_WIDTH-1:0]        tdata_o,
    output logic [ID_W-1:0]             tid_o,
    output logic                        busy_o
);

    state_e                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d, id_q, id_d, idx;
    logic [BUS_WIDTH-1:0]  data_q, data_d;
    logic [BUS_WIDTH-1:0]  words [NB_REQ];
    logic [NB_REQ-1:0]     grant;
    logic                  any, load_en;

    for (genvar g = 0; g < NB_REQ; g++) begin : g_words
        assign words[g] = tdata_i[g*BUS_WIDTH +: BUS_WIDTH];
    end

    rr_picker #(.NB_REQ(NB_REQ), .ID_W(ID_W)) u_picker (
        .req_i   (tvalid_i),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (idx),
        .any_o   (any)
    );

    always_comb begin
        load_en = (state_q == IDLE) || tready_o;
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        data_d  = data_q;
        if (load_en) begin
            state_d = any ? SEND : IDLE;
            if (any) begin
                data_d = words[idx];
                id_d   = idx;
                ptr_d  = (idx == ID_W'(NB_REQ - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            data_q  <= data_d;
        end
    end

    // Reset gates ready so no requester sees a handshake while the slot is being cleared.
    assign tready_i = (load_en && !arst) ? grant : '0;
    assign tvalid_o = (state_q == SEND);
    assign busy_o   = tvalid_o;
    assign tdata_o  = data_q;
    assign tid_o    = id_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: directed vectors with a scoreboard of expected {id,data} transfers.
module tb_data_bus_arbiter;

    logic        aclk = 1'b0;
    logic        arst;
    logic [3:0]  tvalid_i, tready_i;
    logic [31:0] tdata_i;
    logic        tvalid_o, tready_o, busy_o;
    logic [7:0]  tdata_o;
    logic [1:0]  tid_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_q [$];

    data_bus_arbiter #(.NB_REQ(4), .BUS_WIDTH(8)) dut (
        .aclk     (aclk),
        .arst     (arst),
        .tvalid_i (tvalid_i),
        .tready_i (tready_i),
        .tdata_i  (tdata_i),
        .tvalid_o (tvalid_o),
        .tready_o (tready_o),
        .tdata_o  (tdata_o),
        .tid_o    (tid_o),
        .busy_o   (busy_o)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    // Monitor: every accepted output transfer must match the next expected entry.
    always @(negedge aclk) begin
        if (!arst && tvalid_o && tready_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_xfer", {22'd0, tid_o, tdata_o}, 32'hFFFF_FFFF);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("sb_xfer", {22'd0, tid_o, tdata_o}, {22'd0, e});
            end
        end
    end

    initial begin
        arst     = 1'b1;
        tvalid_i = 4'hF;
        tdata_i  = {8'h13, 8'h12, 8'h11, 8'h10};
        tready_o = 1'b0;
        repeat (2) @(negedge aclk);
        check("rst_tvalid_o", tvalid_o, 0);
        check("rst_tready_i", tready_i, 0);
        check("rst_tdata_o", tdata_o, 0);
        check("rst_tid_o", tid_o, 0);
        check("rst_busy_o", busy_o, 0);

        cyc();
        arst     = 1'b0;
        tvalid_i = 4'b0100;
        tdata_i  = {8'h13, 8'hA5, 8'h11, 8'h10};
        tready_o = 1'b1;
        exp_q.push_back({2'd2, 8'hA5});
        @(negedge aclk);
        check("single_tready_i", tready_i, 4'b0100);
        check("single_pre_tvalid", tvalid_o, 0);
        cyc();
        tvalid_i = 4'b0000;
        @(negedge aclk);
        check("single_tvalid_o", tvalid_o, 1);
        check("single_tdata_o", tdata_o, 8'hA5);
        check("single_tid_o", tid_o, 2);
        check("single_tready_off", tready_i, 0);

        cyc();
        arst = 1'b1;
        cyc();
        arst     = 1'b0;
        tvalid_i = 4'hF;
        tdata_i  = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 8; i++) exp_q.push_back({2'(i % 4), 8'h10 + 8'(i % 4)});
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 7) tready_o = 1'b0;
            @(negedge aclk);
            check("fair_tvalid_o", tvalid_o, 1);
            check("fair_tid_o", tid_o, i % 4);
        end

        repeat (5) begin
            cyc();
            @(negedge aclk);
            check("bp_tdata_o", tdata_o, 8'h13);
            check("bp_tid_o", tid_o, 3);
            check("bp_tready_i", tready_i, 0);
            check("bp_tvalid_o", tvalid_o, 1);
        end
        cyc();
        tready_o = 1'b1;
        tvalid_i = 4'b1000;
        tdata_i  = {8'hC3, 8'h12, 8'h11, 8'h10};
        @(negedge aclk);
        check("bp_release_tready_i", tready_i, 4'b1000);
        cyc();
        tready_o = 1'b0;
        tvalid_i = 4'b0000;
        @(negedge aclk);
        check("mid_tid_o", tid_o, 3);
        check("mid_tdata_o", tdata_o, 8'hC3);
        check("mid_tvalid_o", tvalid_o, 1);
        #1;
        arst = 1'b1;
        #1;
        check("mid_rst_tvalid_o", tvalid_o, 0);
        check("mid_rst_busy_o", busy_o, 0);
        check("mid_rst_tid_o", tid_o, 0);
        check("mid_rst_tdata_o", tdata_o, 0);

        cyc();
        arst     = 1'b0;
        tvalid_i = 4'hF;
        tdata_i  = {8'h13, 8'h12, 8'h11, 8'h10};
        tready_o = 1'b1;
        exp_q.push_back({2'd0, 8'h10});
        exp_q.push_back({2'd1, 8'h11});
        @(negedge aclk);
        check("post_rst_pre_tvalid", tvalid_o, 0);
        check("post_rst_tready_i", tready_i, 4'b0001);
        cyc();
        @(negedge aclk);
        check("post_rst_first_tid", tid_o, 0);
        cyc();
        tvalid_i = 4'b0000;
        @(negedge aclk);
        check("post_rst_second_tid", tid_o, 1);
        cyc();
        @(negedge aclk);
        check("final_idle_tvalid", tvalid_o, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 Parameter NB_REQ, 4, number of requesters (2..16).
REQ-002 Parameter BUS_WIDTH, 8, data width per requester, equal to the synchronizer bus width.
REQ-003 Localparam ID_W = max(1, clog2(NB_REQ)), width of the source ID.
REQ-004 aclk  in  1  single clock, all logic rising-edge.
REQ-005 arst  in  1  asynchronous active-high reset.
REQ-006 tvalid_i  in  NB_REQ  per-requester valid.
REQ-007 tready_i  out  NB_REQ  per-requester ready.
REQ-008 tdata_i  in  NB_REQ*BUS_WIDTH  requester k occupies bits [k*BUS_WIDTH +: BUS_WIDTH].
REQ-009 tvalid_o  out  1  valid toward the data_bus_synchro input.
REQ-010 tready_o  in  1  ready from the data_bus_synchro input.
REQ-011 tdata_o  out  BUS_WIDTH  registered granted word.
REQ-012 tid_o  out  ID_W  index of the requester whose word is on tdata_o.
REQ-013 busy_o  out  1  high while tvalid_o is high.

Function
REQ-014 The FSM SHALL have two states: IDLE (output register empty) and SEND (output register full, tvalid_o=1).
REQ-015 load_en SHALL be (state==IDLE) or (state==SEND and tready_o).
REQ-016 The grant SHALL be round-robin: the first k with tvalid_i[k]=1, searching ptr, ptr+1, ... modulo NB_REQ.
REQ-017 tready_i[k] SHALL be load_en AND grant[k], so at most one bit is high; it is combinational from tready_o, tvalid_i and the state.
REQ-018 On load_en with any tvalid_i high, the block SHALL register tdata_o = word k and tid_o = k, set ptr = (k+1) mod NB_REQ, and enter or stay in SEND.
REQ-019 On load_en with no tvalid_i high, the block SHALL enter IDLE with tvalid_o=0 and leave tdata_o and tid_o unchanged.
REQ-020 In SEND with tready_o=0, tvalid_o, tdata_o and tid_o SHALL hold stable; no tready_i bit is asserted.
REQ-021 Latency SHALL be 1 cycle from the requester handshake to tvalid_o.
REQ-022 Sustained throughput SHALL be 1 word per cycle while tready_o=1 and requests are pending (back-to-back reload in SEND).
REQ-023 ptr SHALL wrap from NB_REQ-1 to 0.
REQ-024 ptr SHALL change only on a load.
REQ-025 A requester that drops tvalid_i before being granted SHALL lose nothing; the arbiter only samples the current tvalid_i.
REQ-026 With all requesters continuously valid, the grant order SHALL be 0,1,...,NB_REQ-1,0; no requester waits more than NB_REQ-1 loads.

Reset
REQ-027 The arst assertion SHALL, asynchronously, force state=IDLE, tvalid_o=0, tdata_o=0, tid_o=0, ptr=0, busy_o=0 and tready_i=0.
REQ-028 A word held in SEND when reset asserts SHALL be discarded.
REQ-029 Release SHALL be synchronous to aclk; the first grant SHALL occur on the first rising edge after release.

Structure
REQ-030 The FSM state encoding and the ID_W computation SHALL reside in the shared package cdc_pkg.
REQ-031 The combinational rotate-priority picker SHALL be the sub-module rr_picker (inputs req and ptr; outputs a one-hot grant and its index).
REQ-032 The datapath SHALL be a single BUS_WIDTH+ID_W output register with no other storage.

Verification (NB_REQ=4, BUS_WIDTH=8)
REQ-033 Reset test: hold arst=1 with tvalid_i=4'hF, then sample -> tvalid_o=0, tready_i=0, tdata_o=8'h00, tid_o=0.
REQ-034 Single requester test: tvalid_i=4'b0100, word 2 = 8'hA5, tready_o=1 -> tready_i=4'b0100 for one cycle; next cycle tvalid_o=1, tdata_o=8'hA5, tid_o=2.
REQ-035 Fairness test: all valid, words 8'h10/8'h11/8'h12/8'h13, tready_o=1 for 8 cycles -> tid_o sequence 0,1,2,3,0,1,2,3 with matching data and tvalid_o high every cycle.
REQ-036 Backpressure test: tready_o=0 for 5 cycles after load -> tdata_o/tid_o stable, tready_i=0; on tready_o=1 the next word loads in the same cycle.
REQ-037 Mid-operation reset test: assert arst while in SEND with tid_o=3 -> tvalid_o=0 immediately; after release with all valid, the first tid_o=0.
REQ-038 Integration test: instantiate with data_bus_synchro (fast aclk, slow output clock) and send 100 random words from 4 requesters -> every word appears exactly once at the synchronizer output, in per-requester order.
